// File: rtl/change_dispenser_if.sv
// Bundle of request, hopper and status signals between the vending FSM side and the dispenser.
// The master modport is the vending/hopper environment and the slave modport is the dispenser.
interface change_dispenser_if #(
  parameter int CNT_W = 8
);
  logic             req;
  logic             vend;
  logic [2:0]       amt;
  logic             hop_ack;
  logic             refill1;
  logic             refill2;
  logic             ready;
  logic             prod_pulse;
  logic             hop1_drive;
  logic             hop2_drive;
  logic             done;
  logic             short_err;
  logic             jam_err;
  logic [2:0]       owed;
  logic [CNT_W-1:0] one_cnt;
  logic [CNT_W-1:0] two_cnt;
  logic [15:0]      paid_total;

  modport master (
    output req, vend, amt, hop_ack, refill1, refill2,
    input  ready, prod_pulse, hop1_drive, hop2_drive, done, short_err, jam_err,
           owed, one_cnt, two_cnt, paid_total
  );

  modport slave (
    input  req, vend, amt, hop_ack, refill1, refill2,
    output ready, prod_pulse, hop1_drive, hop2_drive, done, short_err, jam_err,
           owed, one_cnt, two_cnt, paid_total
  );
endinterface

// File: rtl/change_dispenser.sv
// Vend/change payout controller driving a $2 and a $1 hopper with per-coin ack and jam timeout.
// Optional macro CHANGE_AUDIT_EN enables the 16-bit paid_total accumulator (otherwise tied to 0).
module change_dispenser #(
  parameter int CNT_W       = 8,
  parameter int INIT_ONE    = 20,
  parameter int INIT_TWO    = 20,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  change_dispenser_if.slave bus
);

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] PROD = 3'd1;
  localparam logic [2:0] SEL  = 3'd2;
  localparam logic [2:0] DRV1 = 3'd3;
  localparam logic [2:0] DRV2 = 3'd4;
  localparam logic [2:0] REL  = 3'd5;
  localparam logic [2:0] DONE = 3'd6;

  localparam int TO_W = $clog2(ACK_TIMEOUT);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  logic [2:0]            state_reg, state_next;
  logic [2:0]            rem_reg, rem_next;
  logic [TO_W-1:0]       tmo_reg, tmo_next;
  logic                  short_reg, short_next;
  logic [2:0]            owed_reg, owed_next;
  logic                  jam_reg, jam_next;
  logic [1:0][CNT_W-1:0] inv;
  logic [1:0]            dec;
  logic [1:0]            clr;
  logic [1:0]            refill;
  logic                  is_two;
  logic [1:0]            coin_val;
  logic                  ack_take;

  assign refill   = {bus.refill2, bus.refill1};
  assign is_two   = (state_reg == DRV2);
  assign coin_val = is_two ? 2'd2 : 2'd1;
  assign ack_take = ((state_reg == DRV1) || (state_reg == DRV2)) && bus.hop_ack;

  always_comb begin
    state_next = state_reg;
    rem_next   = rem_reg;
    tmo_next   = tmo_reg;
    short_next = short_reg;
    owed_next  = owed_reg;
    jam_next   = jam_reg;
    dec        = 2'b00;
    clr        = 2'b00;
    case (state_reg)
      IDLE: begin
        if (bus.req) begin
          rem_next   = bus.amt;
          short_next = 1'b0;
          owed_next  = 3'd0;
          state_next = bus.vend ? PROD : SEL;
        end
      end
      PROD: state_next = SEL;
      SEL: begin
        tmo_next = '0;
        if (rem_reg >= 3'd2 && inv[1] != '0) begin
          state_next = DRV2;
        end else if (rem_reg >= 3'd1 && inv[0] != '0) begin
          state_next = DRV1;
        end else begin
          short_next = (rem_reg != 3'd0);
          owed_next  = rem_reg;
          state_next = DONE;
        end
      end
      DRV1, DRV2: begin
        if (bus.hop_ack) begin
          dec        = is_two ? 2'b10 : 2'b01;
          rem_next   = rem_reg - {1'b0, coin_val};
          state_next = REL;
        end else if (tmo_reg == TO_LAST) begin
          // A jammed hopper is treated as empty so SEL falls through to the other one.
          jam_next   = 1'b1;
          clr        = is_two ? 2'b10 : 2'b01;
          state_next = SEL;
        end else begin
          tmo_next = tmo_reg + 1'b1;
        end
      end
      REL: begin
        if (!bus.hop_ack) state_next = SEL;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      rem_reg   <= 3'd0;
      tmo_reg   <= '0;
      short_reg <= 1'b0;
      owed_reg  <= 3'd0;
      jam_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      rem_reg   <= rem_next;
      tmo_reg   <= tmo_next;
      short_reg <= short_next;
      owed_reg  <= owed_next;
      jam_reg   <= jam_next;
    end
  end

  // Index 0 is the $1 hopper, index 1 the $2 hopper; refill and payout together cancel.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_hopper
      localparam int INIT_VAL = (gi == 0) ? INIT_ONE : INIT_TWO;
      logic [CNT_W-1:0] cnt_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cnt_reg <= CNT_W'(INIT_VAL);
        end else if (clr[gi]) begin
          cnt_reg <= '0;
        end else if (refill[gi] && !dec[gi] && cnt_reg != '1) begin
          cnt_reg <= cnt_reg + 1'b1;
        end else if (dec[gi] && !refill[gi] && cnt_reg != '0) begin
          cnt_reg <= cnt_reg - 1'b1;
        end
      end
      assign inv[gi] = cnt_reg;
    end
  endgenerate

`ifdef CHANGE_AUDIT_EN
  logic [15:0] paid_reg;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      paid_reg <= 16'd0;
    end else if (ack_take) begin
      paid_reg <= paid_reg + {14'd0, coin_val};
    end
  end
  assign bus.paid_total = paid_reg;
`else
  logic unused_audit;
  assign unused_audit   = ack_take;
  assign bus.paid_total = 16'd0;
`endif

  assign bus.ready      = (state_reg == IDLE);
  assign bus.prod_pulse = (state_reg == PROD);
  assign bus.hop1_drive = (state_reg == DRV1);
  assign bus.hop2_drive = (state_reg == DRV2);
  assign bus.done       = (state_reg == DONE);
  assign bus.short_err  = short_reg;
  assign bus.owed       = owed_reg;
  assign bus.jam_err    = jam_reg;
  assign bus.one_cnt    = inv[0];
  assign bus.two_cnt    = inv[1];

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: a coin-level reference model predicts each request's
// outcome, a hopper responder acks drives, and a monitor compares at every done strobe.
module tb_change_dispenser;
  localparam int CNT_W = 8;
  localparam int MAXC  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req_s = 1'b0, vend_s = 1'b0, ack_s = 1'b0;
  logic [2:0] amt_s = 3'd0;
  logic       r1_s = 1'b0, r2_s = 1'b0, r2_pay = 1'b0;
  bit         jam2 = 1'b0, refpay = 1'b0;

  change_dispenser_if #(.CNT_W(CNT_W)) bus();

  assign bus.req     = req_s;
  assign bus.vend    = vend_s;
  assign bus.amt     = amt_s;
  assign bus.hop_ack = ack_s;
  assign bus.refill1 = r1_s;
  assign bus.refill2 = r2_s | r2_pay;

  change_dispenser #(.CNT_W(CNT_W), .INIT_ONE(20), .INIT_TWO(20), .ACK_TIMEOUT(15)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int n_prod;
    int n1;
    int n2;
    int short_e;
    int owed;
    int one;
    int two;
    int jam;
    int paid;
    int lat;
    int issue_cyc;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_one = 20, m_two = 20, m_jam = 0, m_paid = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  // Reference model: pay greedily coin by coin from the current stock.
  task automatic predict(input int amt, input bit vend, input bit j2, input bit rp, output exp_t e);
    int rem;
    rem = amt;
    e.n_prod = vend ? 1 : 0;
    e.n1 = 0;
    e.n2 = 0;
    while (1) begin
      if (rem >= 2 && m_two > 0) begin
        e.n2++;
        if (j2) begin
          m_two = 0;
          m_jam = 1;
        end else begin
          if (!rp) m_two--;
          rem -= 2;
          m_paid = (m_paid + 2) % 65536;
        end
      end else if (rem >= 1 && m_one > 0) begin
        e.n1++;
        m_one--;
        rem -= 1;
        m_paid = (m_paid + 1) % 65536;
      end else begin
        break;
      end
    end
    e.short_e = (rem != 0) ? 1 : 0;
    e.owed = rem;
    e.one = m_one;
    e.two = m_two;
    e.jam = m_jam;
`ifdef CHANGE_AUDIT_EN
    e.paid = m_paid;
`else
    e.paid = 0;
`endif
    e.lat = (amt == 0) ? (vend ? 3 : 2) : -1;
    e.issue_cyc = 0;
  endtask

  // Hopper: ack each drive after 1..3 cycles, hold the sensor 1..3 cycles.
  initial begin
    bit is2;
    int d, h;
    forever begin
      @(negedge clk);
      if (!rst && (bus.hop1_drive || (bus.hop2_drive && !jam2))) begin
        is2 = bus.hop2_drive;
        d = $urandom_range(1, 3);
        h = $urandom_range(1, 3);
        repeat (d - 1) @(negedge clk);
        ack_s = 1'b1;
        r2_pay = is2 && refpay;
        @(negedge clk);
        r2_pay = 1'b0;
        repeat (h - 1) @(negedge clk);
        ack_s = 1'b0;
      end
    end
  end

  // Monitor: count strobes and drive starts, compare at each done.
  initial begin
    int n_prod_m, n1_m, n2_m;
    bit p1, p2;
    exp_t e;
    n_prod_m = 0; n1_m = 0; n2_m = 0; p1 = 0; p2 = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        n_prod_m = 0; n1_m = 0; n2_m = 0; p1 = 0; p2 = 0;
      end else begin
        if (bus.prod_pulse) n_prod_m++;
        if (bus.hop1_drive && !p1) n1_m++;
        if (bus.hop2_drive && !p2) n2_m++;
        p1 = bus.hop1_drive;
        p2 = bus.hop2_drive;
        if (bus.done) begin
          if (sb.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = sb.pop_front();
            chk("prod_pulses", n_prod_m, e.n_prod);
            chk("hop2_drives", n2_m, e.n2);
            chk("hop1_drives", n1_m, e.n1);
            chk("short_err", int'(bus.short_err), e.short_e);
            chk("owed", int'(bus.owed), e.owed);
            chk("one_cnt", int'(bus.one_cnt), e.one);
            chk("two_cnt", int'(bus.two_cnt), e.two);
            chk("jam_err", int'(bus.jam_err), e.jam);
            chk("paid_total", int'(bus.paid_total), e.paid);
            if (e.lat >= 0) chk("done_latency", cyc - e.issue_cyc, e.lat);
            $display("txn done: owed=%0d short=%0d one=%0d two=%0d jam=%0d paid=%0d",
                     bus.owed, bus.short_err, bus.one_cnt, bus.two_cnt, bus.jam_err, bus.paid_total);
          end
          n_prod_m = 0; n1_m = 0; n2_m = 0;
        end
      end
    end
  end

  task automatic refill(input int which, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (which == 1) begin
        r1_s = 1'b1;
        m_one = (m_one < MAXC) ? m_one + 1 : MAXC;
      end else begin
        r2_s = 1'b1;
        m_two = (m_two < MAXC) ? m_two + 1 : MAXC;
      end
    end
    @(negedge clk);
    r1_s = 1'b0;
    r2_s = 1'b0;
  endtask

  task automatic run_req(input int amt, input bit vend, input bit j2, input bit rp);
    exp_t e;
    int guard;
    jam2 = j2;
    refpay = rp;
    predict(amt, vend, j2, rp, e);
    @(negedge clk);
    chk("ready_before_req", int'(bus.ready), 1);
    e.issue_cyc = cyc;
    sb.push_back(e);
    req_s = 1'b1;
    vend_s = vend;
    amt_s = 3'(amt);
    @(negedge clk);
    guard = 0;
    // Stray requests while busy must be ignored.
    while (!bus.done && guard < 400) begin
      req_s = ($urandom_range(0, 3) == 0);
      vend_s = 1'($urandom);
      amt_s = 3'($urandom);
      @(negedge clk);
      guard++;
    end
    req_s = 1'b0;
    if (guard >= 400) chk("done_timeout", 0, 1);
    jam2 = 1'b0;
    refpay = 1'b0;
  endtask

  task automatic reset_check(input string tag);
    chk({tag, "_ready"}, int'(bus.ready), 1);
    chk({tag, "_hop1"}, int'(bus.hop1_drive), 0);
    chk({tag, "_hop2"}, int'(bus.hop2_drive), 0);
    chk({tag, "_done"}, int'(bus.done), 0);
    chk({tag, "_jam"}, int'(bus.jam_err), 0);
    chk({tag, "_owed"}, int'(bus.owed), 0);
    chk({tag, "_one"}, int'(bus.one_cnt), 20);
    chk({tag, "_two"}, int'(bus.two_cnt), 20);
    chk({tag, "_paid"}, int'(bus.paid_total), 0);
  endtask

  initial begin
    int guard;
    repeat (2) @(negedge clk);
    reset_check("reset");
    rst = 1'b0;

    run_req(3, 1, 0, 0);
    run_req(0, 1, 0, 0);
    run_req(0, 0, 0, 0);
    run_req(2, 0, 1, 0);
    run_req(7, 1, 0, 1);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 3) == 0) begin
        refill(1, $urandom_range(0, 3));
        refill(2, $urandom_range(0, 3));
      end
      run_req($urandom_range(0, 7), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0));
    end

    // Asynchronous reset in the middle of a $2 drive.
    refill(2, 2);
    jam2 = 1'b1;
    @(negedge clk);
    req_s = 1'b1; vend_s = 1'b0; amt_s = 3'd2;
    @(negedge clk);
    req_s = 1'b0;
    guard = 0;
    while (!bus.hop2_drive && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    chk("reach_drv2", int'(bus.hop2_drive), 1);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 reset_check("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    jam2 = 1'b0;
    m_one = 20; m_two = 20; m_jam = 0; m_paid = 0;

    run_req(7, 0, 0, 1);
    run_req(3, 1, 0, 0);
    refill(1, 240);
    chk("one_cnt_saturated", int'(bus.one_cnt), m_one);
    run_req(1, 0, 0, 0);
    run_req(0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
